// File: rtl/seg_digit_scanner_pkg.sv
// seg_digit_scanner_pkg
// Shared definitions for the multiplexed seven-segment display scanner:
// the scan FSM state type and the default geometry/timing constants.
package seg_digit_scanner_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_SLOT_CYCLES  = 50000;
  localparam int DEF_BLANK_CYCLES = 16;

endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer
// Counts cycles inside the current phase of a digit slot and raises the
// end-of-phase strobes the scan FSM uses to advance.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   state       current scan phase (BLANK or SHOW) owned by the FSM
//   blank_end   last cycle of the dark phase of a slot
//   slot_end    last cycle of the lit phase, i.e. the end of the whole slot
module seg_slot_timer
  import seg_digit_scanner_pkg::*;
#(
  parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  scan_state_e state,
  output logic        blank_end,
  output logic        slot_end
);

  localparam int CNT_W = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SLOT_CYCLES - BLANK_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign blank_end = (state == ST_BLANK) && (cnt == BLANK_LAST);
  assign slot_end  = (state == ST_SHOW)  && (cnt == SHOW_LAST);

  // The counter restarts at every phase boundary so each phase counts from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (blank_end || slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_digit_scanner.sv
// seg_digit_scanner
// Time-multiplexes NUM_DIGITS hex nibbles onto one shared character bus.
// Each digit slot starts with a dark (anti-ghosting) phase, then lights the
// digit. New values are double-buffered and only committed at frame wrap.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   value         NUM_DIGITS hex nibbles, nibble 0 = least significant digit
//   value_valid   load request; accepted when value_ready is high
//   value_ready   shadow register empty
//   blank_lz      leading-zero suppression enable
//   char          nibble of the digit being scanned (to external decoder)
//   digit_en      active-low digit enables, at most one low
//   frame_tick    one-cycle pulse at the start of each frame after the first
module seg_digit_scanner
  import seg_digit_scanner_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    value_valid,
  output logic                    value_ready,
  input  logic                    blank_lz,
  output logic [3:0]              char,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_tick
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_e             state, state_nx;
  logic [IDX_W-1:0]        idx, idx_nx;
  logic                    wrap, blank_end, slot_end, load, full;
  logic [4*NUM_DIGITS-1:0] disp, shadow, disp_nx;
  logic [3:0]              char_nx;
  logic [NUM_DIGITS-1:0]   sel, digit_en_nx;

  // A digit is dark when suppression is on, it is not digit 0, and it and
  // every more significant nibble are zero.
  function automatic logic suppressed(input logic [4*NUM_DIGITS-1:0] d,
                                      input logic [IDX_W-1:0]        k,
                                      input logic                    lz);
    logic nonzero;
    nonzero = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(k)) && (d[4*i +: 4] != 4'h0)) nonzero = 1'b1;
    end
    return lz && (k != '0) && !nonzero;
  endfunction

  seg_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_slot_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

  assign value_ready = !full;
  assign load        = value_valid && !full;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BLANK;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // FSM next state
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    wrap     = 1'b0;
    case (state)
      ST_BLANK: if (blank_end) state_nx = ST_SHOW;
      ST_SHOW: begin
        if (slot_end) begin
          state_nx = ST_BLANK;
          if (idx == LAST_IDX) begin
            idx_nx = '0;
            wrap   = 1'b1;
          end else begin
            idx_nx = idx + IDX_W'(1);
          end
        end
      end
      default: state_nx = ST_BLANK;
    endcase
  end

  // FSM outputs: computed from the next state so the registered outputs
  // line up with the state they describe, including a freshly committed disp.
  always_comb begin
    disp_nx     = (wrap && full) ? shadow : disp;
    char_nx     = disp_nx[{idx_nx, 2'b00} +: 4];
    sel         = '0;
    sel[idx_nx] = 1'b1;
    digit_en_nx = '1;
    if ((state_nx == ST_SHOW) && !suppressed(disp_nx, idx_nx, blank_lz)) begin
      digit_en_nx = ~sel;
    end
  end

  // Display buffers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp       <= '0;
      shadow     <= '0;
      full       <= 1'b0;
      char       <= 4'h0;
      digit_en   <= '1;
      frame_tick <= 1'b0;
    end else begin
      // A load on the wrap edge (full was 0) lands in shadow and waits for
      // the next wrap; commit and load are mutually exclusive via full.
      if (wrap && full) begin
        disp <= shadow;
        full <= 1'b0;
      end else if (load) begin
        shadow <= value;
        full   <= 1'b1;
      end
      char       <= char_nx;
      digit_en   <= digit_en_nx;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Testbench for seg_digit_scanner with NUM_DIGITS=4, SLOT_CYCLES=8,
// BLANK_CYCLES=2. Position n counts clock edges since reset release, so the
// outputs seen during cycle n reflect the state after n edges.
module tb_seg_digit_scanner;

  localparam int ND    = 4;
  localparam int SC    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * SC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic        value_valid = 1'b0;
  logic        blank_lz = 1'b0;
  logic        value_ready, frame_tick;
  logic [3:0]  char;
  logic [3:0]  digit_en;

  always #5 clk = ~clk;

  seg_digit_scanner #(
    .NUM_DIGITS   (ND),
    .SLOT_CYCLES  (SC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .blank_lz    (blank_lz),
    .char        (char),
    .digit_en    (digit_en),
    .frame_tick  (frame_tick)
  );

  int vecs = 0;
  int miss = 0;

  // Reference model state
  int          n;
  logic [15:0] m_disp, m_shadow;
  logic        m_full, m_lz;

  // Observation window: which digits lit and what char each showed
  int          obs_lo = -1, obs_hi = -1;
  logic [3:0]  obs_lit;
  logic [15:0] obs_chars;

  typedef struct {
    logic [15:0] val;
    logic        lz;
    logic [3:0]  exp_lit;
    logic [15:0] exp_chars;
  } frame_vec_t;

  frame_vec_t tbl[8];

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s at n=%0d: got %h, expected %h", name, n, act, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; m_disp = 16'h0; m_shadow = 16'h0; m_full = 1'b0; m_lz = 1'b0;
  endtask

  // One clock edge of the behavioural model: frame boundaries every FRAME
  // edges commit a pending value, otherwise an empty shadow accepts a load.
  task automatic model_edge();
    n++;
    m_lz = blank_lz;
    if ((n % FRAME == 0) && m_full) begin
      m_disp = m_shadow;
      m_full = 1'b0;
    end else if (value_valid && !m_full) begin
      m_shadow = value;
      m_full   = 1'b1;
    end
  endtask

  task automatic check_cycle();
    int slot;
    logic show, sup;
    logic [3:0] e_en, e_char;
    logic e_tick;
    slot   = (n / SC) % ND;
    show   = (n % SC) >= BC;
    e_char = 4'((m_disp >> (4 * slot)) & 16'hF);
    sup    = m_lz && (slot != 0) && ((m_disp >> (4 * slot)) == 16'h0);
    e_en   = (show && !sup) ? ~(4'b0001 << slot) : 4'hF;
    e_tick = (n > 0) && (n % FRAME == 0);
    cmp("outputs{en,char,tick,ready}", {6'b0, digit_en, char, frame_tick, value_ready},
        {6'b0, e_en, e_char, e_tick, !m_full});
    if (n >= obs_lo && n <= obs_hi) begin
      for (int k = 0; k < ND; k++) begin
        if (!digit_en[k]) begin
          obs_lit[k] = 1'b1;
          obs_chars[4*k +: 4] = char;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic load(input logic [15:0] v);
    value = v; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
  endtask

  task automatic observe(input int lo, input int hi);
    obs_lit = 4'h0; obs_chars = 16'h0; obs_lo = lo; obs_hi = hi;
    run_to(hi);
    obs_lo = -1; obs_hi = -1;
  endtask

  // Reset asserted mid-cycle: outputs must reset with no clock edge.
  task automatic apply_reset();
    value_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 cmp("async_reset{en,char,tick,ready}", {6'b0, digit_en, char, frame_tick, value_ready},
           {6'b0, 4'hF, 4'h0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n=%0d", n);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h1234, 1'b0, 4'b1111, 16'h1234};
    tbl[1] = '{16'h0050, 1'b1, 4'b0011, 16'h0050};
    tbl[2] = '{16'h0000, 1'b1, 4'b0001, 16'h0000};
    tbl[3] = '{16'h0050, 1'b0, 4'b1111, 16'h0050};
    tbl[4] = '{16'h0000, 1'b0, 4'b1111, 16'h0000};
    tbl[5] = '{16'h1000, 1'b1, 4'b1111, 16'h1000};
    tbl[6] = '{16'h0300, 1'b1, 4'b0111, 16'h0300};
    tbl[7] = '{16'hF00A, 1'b1, 4'b1111, 16'hF00A};
    model_reset();

    // Release, first slots, load and ignored second load
    apply_reset();
    cmp("en_c0", {12'b0, digit_en}, 16'hF);
    cmp("ready_c0", {15'b0, value_ready}, 16'h1);
    run_to(1);  cmp("en_c1", {12'b0, digit_en}, 16'hF);
    run_to(2);  cmp("en_c2", {12'b0, digit_en}, 16'hE);
    run_to(5);  cmp("en_c5", {12'b0, digit_en}, 16'hE);
    load(16'h1234);
    cmp("ready_c6", {15'b0, value_ready}, 16'h0);
    run_to(7);  cmp("en_c7", {12'b0, digit_en}, 16'hE);
    run_to(8);  cmp("en_c8", {12'b0, digit_en}, 16'hF);
    run_to(10); cmp("en_c10", {12'b0, digit_en}, 16'hD);
    load(16'hBEEF);
    run_to(31); cmp("tick_c31", {15'b0, frame_tick}, 16'h0);
    run_to(32); cmp("tick_c32", {15'b0, frame_tick}, 16'h1);
    run_to(33); cmp("ready_c33", {15'b0, value_ready}, 16'h1);
    cmp("tick_c33", {15'b0, frame_tick}, 16'h0);
    observe(33, 63);
    cmp("frame1_chars", obs_chars, 16'h1234);
    cmp("frame1_lit", {12'b0, obs_lit}, 16'hF);

    // Load presented on the exact wrap edge waits for the following wrap
    run_to(95);
    load(16'hA5C3);
    cmp("wrapload_tick", {15'b0, frame_tick}, 16'h1);
    cmp("wrapload_ready", {15'b0, value_ready}, 16'h0);
    observe(96, 127);
    cmp("wrapload_old_chars", obs_chars, 16'h1234);
    run_to(128);
    cmp("wrapload_tick2", {15'b0, frame_tick}, 16'h1);
    cmp("wrapload_ready2", {15'b0, value_ready}, 16'h1);
    observe(128, 159);
    cmp("wrapload_new_chars", obs_chars, 16'hA5C3);

    // Reset in the middle of digit 2 SHOW
    run_to(180);
    cmp("en_digit2", {12'b0, digit_en}, 16'hB);
    apply_reset();
    run_to(2);
    cmp("restart_en", {12'b0, digit_en}, 16'hE);
    cmp("restart_char", {12'b0, char}, 16'h0);
    run_to(33);
    cmp("restart_no_commit", {12'b0, char}, 16'h0);

    // Table: value committed at the first wrap, inspected over the next frame
    for (int i = 0; i < 8; i++) begin
      apply_reset();
      blank_lz = tbl[i].lz;
      run_to(1);
      load(tbl[i].val);
      run_to(32);
      observe(32, 63);
      cmp($sformatf("tbl%0d_lit", i), {12'b0, obs_lit}, {12'b0, tbl[i].exp_lit});
      cmp($sformatf("tbl%0d_chars", i), obs_chars, tbl[i].exp_chars);
    end

    // Random traffic against the model, with one reset part way through
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      case ($urandom_range(0, 5))
        0: value = 16'($urandom);
        1: value = 16'($urandom) & 16'h0FFF;
        2: value = 16'($urandom) & 16'h00FF;
        3: value = 16'($urandom) & 16'h000F;
        4: value = 16'h0000;
        default: value = 16'($urandom) & 16'hF0F0;
      endcase
      value_valid = ($urandom_range(0, 9) == 0);
      blank_lz    = ($urandom_range(0, 3) != 0);
      if (c == 1000) apply_reset();
      else tick();
    end
    value_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/seg_digit_scanner.md
SEG_DIGIT_SCANNER -- requirements
Module: seg_digit_scanner

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, range 2..8.
REQ-002 Parameter SLOT_CYCLES, default 50000: clock cycles per digit slot; SHALL be at least BLANK_CYCLES+1.
REQ-003 Parameter BLANK_CYCLES, default 16: anti-ghosting dark cycles at the start of each slot; SHALL be at least 1.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 value  in  4*NUM_DIGITS  hex digits to display; nibble k is digit k, and digit 0 is least significant.
REQ-007 value_valid  in  1  load request.
REQ-008 value_ready  out  1  shadow register empty; a load SHALL occur when value_valid and value_ready are both 1.
REQ-009 blank_lz  in  1  leading-zero suppression enable, sampled every cycle.
REQ-010 char  out  4  current digit nibble, feeding the downstream seven-segment decoder.
REQ-011 digit_en  out  NUM_DIGITS  active-low digit enables; at most one bit SHALL be 0 at any time.
REQ-012 frame_tick  out  1  one-cycle pulse marking the start of a frame.

Function
REQ-013 The block SHALL hold a display register (disp) and a shadow register (shadow) with a full flag.
- value_ready = !full.
- On a load, shadow <= value and full <= 1.
REQ-014 Two-state FSM with a slot counter and a digit index idx:
- BLANK: runs BLANK_CYCLES cycles, then goes to SHOW.
- SHOW: runs SLOT_CYCLES-BLANK_CYCLES cycles, then goes to BLANK with idx <= idx+1, wrapping from NUM_DIGITS-1 to 0.
REQ-015 char SHALL be registered and equal disp nibble idx in both states, so it is stable before the digit is enabled.
REQ-016 In BLANK, digit_en SHALL be all ones.
REQ-017 In SHOW, digit_en[idx] SHALL be 0 unless idx is suppressed; every other bit SHALL be 1.
REQ-018 Digit idx is suppressed iff all of the following hold:
- blank_lz=1;
- idx != 0;
- disp nibbles idx..NUM_DIGITS-1 are all zero.
Digit 0 is never suppressed.
REQ-019 Frame wrap, i.e. the edge where idx goes NUM_DIGITS-1 -> 0 and the FSM enters BLANK:
- frame_tick SHALL be 1 for exactly the following cycle.
- If full, disp <= shadow and full <= 0.
REQ-020 If a load and a frame wrap occur on the same edge (full was 0), the new value SHALL be captured into shadow and committed at the next wrap, not the current one.
REQ-021 value_valid while value_ready=0 SHALL be ignored; it SHALL NOT overwrite shadow.
REQ-022 Frame period SHALL be exactly NUM_DIGITS*SLOT_CYCLES cycles.
REQ-023 Each digit SHALL be lit for exactly SLOT_CYCLES-BLANK_CYCLES cycles per frame.

Reset
REQ-024 While rst_n=0, all outputs SHALL take these values immediately (asynchronously):
- digit_en = all ones
- char = 0
- frame_tick = 0
- value_ready = 1
REQ-025 Reset SHALL set the internal state as follows:
- FSM = BLANK, idx = 0, counter = 0
- disp = 0, shadow = 0, full = 0
REQ-026 Reset asserted mid-slot or mid-frame SHALL abandon the slot, and no digit SHALL remain enabled.
REQ-027 After reset release, scanning SHALL start at digit 0 in BLANK, and no frame_tick SHALL be issued for this first frame.

Structure
REQ-028 A shared display package SHALL hold:
- the FSM state typedef (ST_BLANK, ST_SHOW);
- the default constants for NUM_DIGITS, SLOT_CYCLES and BLANK_CYCLES.
REQ-029 Slot timing SHALL be a sub-module, seg_slot_timer, which generates slot phase and end-of-slot strobes.
REQ-030 The seven-segment decoder SHALL NOT be instantiated inside this block; char is exported.

Verification
All scenarios use NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2; cycle 0 is the first edge after release.
REQ-031 Reset release -> digit_en=1111 for cycles 0-1, 1110 for cycles 2-7, 1111 at cycle 8, 1101 at cycle 10; value_ready=1.
REQ-032 Load value=16'h1234 at cycle 5 -> value_ready=0 from cycle 6; frame_tick=1 at cycle 32; value_ready=1 at cycle 33; char=4, 3, 2, 1 in slots 0-3 of the next frame.
REQ-033 Committed 16'h0050 with blank_lz=1 -> digits 3 and 2 are never enabled; digit 1 lit with char=5; digit 0 lit with char=0. Committed 16'h0000 -> only digit 0 lit. With blank_lz=0 -> all four digits lit.
REQ-034 Second value_valid with 16'hBEEF while value_ready=0 -> ignored; the first loaded value is displayed after the wrap.
REQ-035 rst_n pulsed low during digit 2 SHOW -> digit_en=1111 with no clock edge needed; disp=0; restart at digit 0 BLANK.
REQ-036 Load presented on the exact wrap edge -> committed at the following wrap, 32 cycles later, not the current one.
